// File: rtl/fft_reorder_if.sv
// fft_reorder_if: sample stream bus for the 32-point FFT output reorder buffer.
// The input side carries bit-reversed butterfly samples, the output side carries
// natural-order bins with their index and a frame-start marker.
interface fft_reorder_if #(
    parameter int DW = 17
) ();
    logic                 valid_i;
    logic signed [DW-1:0] data_in_r;
    logic signed [DW-1:0] data_in_i;
    logic                 valid_o;
    logic signed [DW-1:0] data_out_r;
    logic signed [DW-1:0] data_out_i;
    logic [4:0]           index_o;
    logic                 frame_start_o;

    // Producer of samples / consumer of reordered bins
    modport master (
        output valid_i, data_in_r, data_in_i,
        input  valid_o, data_out_r, data_out_i, index_o, frame_start_o
    );

    // The reorder buffer itself
    modport slave (
        input  valid_i, data_in_r, data_in_i,
        output valid_o, data_out_r, data_out_i, index_o, frame_start_o
    );
endinterface

// File: rtl/fft_reorder.sv
// fft_reorder: 32-point bit-reversed to natural-order reorder buffer.
// Two complex banks ping-pong: one is filled at bitrev5(wr_cnt) while the
// other is streamed out at addresses 0..31. Bin 0 leaves on the cycle after
// the last sample of a frame is accepted; frames may run back to back.
// Optional feature macro: FFT_REORDER_SCALE_EN (1/N scaling, round-half-up).
module fft_reorder #(
    parameter int DW = 17
) (
    input  logic           clk,
    input  logic           rst_n,
    fft_reorder_if.slave   bus
);
    typedef enum logic {R_IDLE, R_OUT} rstate_t;

    function automatic logic [4:0] f_bitrev(input logic [4:0] a);
        return {a[0], a[1], a[2], a[3], a[4]};
    endfunction

    function automatic logic signed [DW-1:0] f_scale(input logic signed [DW-1:0] x);
`ifdef FFT_REORDER_SCALE_EN
        logic signed [DW:0] t;
        t = {x[DW-1], x} + (DW+1)'(16);
        return DW'(t >>> 5);
`else
        return x;
`endif
    endfunction

    // Bank storage; contents are never reset because only completed frames are read.
    logic signed [DW-1:0] r_mem_r [2][32];
    logic signed [DW-1:0] r_mem_i [2][32];

    logic [4:0] r_wr_cnt;
    logic       r_wr_bank;
    logic [1:0] r_ready;
    rstate_t    r_state, w_state_nx;
    logic       r_rd_bank, w_rd_bank_nx;
    logic [4:0] r_idx, w_idx_nx;
    logic       w_load, w_start;
    logic       w_frame_done, w_avail, w_start_bank;
    logic [1:0] w_rdy_set, w_rdy_clr;

    assign w_frame_done = bus.valid_i && (r_wr_cnt == 5'd31);
    assign w_avail      = w_frame_done || (|r_ready);
    // An older pending bank is served before the one completing this edge.
    assign w_start_bank = r_ready[0] ? 1'b0 : (r_ready[1] ? 1'b1 : r_wr_bank);
    assign w_rdy_set    = w_frame_done ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_rdy_clr    = w_start ? (2'b01 << w_start_bank) : 2'b00;

    // Store accepted samples at their bit-reversed address in the write bank.
    always_ff @(posedge clk) begin
        if (bus.valid_i) begin
            r_mem_r[r_wr_bank][f_bitrev(r_wr_cnt)] <= bus.data_in_r;
            r_mem_i[r_wr_bank][f_bitrev(r_wr_cnt)] <= bus.data_in_i;
        end
    end

    // Write counter, bank toggle and ready flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= 1'b0;
            r_ready   <= '0;
        end else begin
            if (bus.valid_i) begin
                r_wr_cnt <= r_wr_cnt + 5'd1;
                if (w_frame_done) r_wr_bank <= ~r_wr_bank;
            end
            r_ready <= (r_ready | w_rdy_set) & ~w_rdy_clr;
        end
    end

    // Read FSM next state: pick the next address to present, or go idle.
    always_comb begin
        w_state_nx   = r_state;
        w_rd_bank_nx = r_rd_bank;
        w_idx_nx     = r_idx;
        w_load       = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (w_avail) begin
                    w_state_nx   = R_OUT;
                    w_start      = 1'b1;
                    w_load       = 1'b1;
                    w_rd_bank_nx = w_start_bank;
                    w_idx_nx     = 5'd0;
                end
            end
            R_OUT: begin
                if (r_idx != 5'd31) begin
                    w_load   = 1'b1;
                    w_idx_nx = r_idx + 5'd1;
                end else if (w_avail) begin
                    w_start      = 1'b1;
                    w_load       = 1'b1;
                    w_rd_bank_nx = w_start_bank;
                    w_idx_nx     = 5'd0;
                end else begin
                    w_state_nx = R_IDLE;
                end
            end
            default: w_state_nx = R_IDLE;
        endcase
    end

    // Read FSM state and read pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= R_IDLE;
            r_rd_bank <= 1'b0;
            r_idx     <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_rd_bank <= w_rd_bank_nx;
            r_idx     <= w_idx_nx;
        end
    end

    // Registered outputs; data and index hold their last value between frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.valid_o       <= 1'b0;
            bus.frame_start_o <= 1'b0;
            bus.data_out_r    <= '0;
            bus.data_out_i    <= '0;
            bus.index_o       <= '0;
        end else if (w_load) begin
            bus.valid_o       <= 1'b1;
            bus.frame_start_o <= (w_idx_nx == 5'd0);
            bus.data_out_r    <= f_scale(r_mem_r[w_rd_bank_nx][w_idx_nx]);
            bus.data_out_i    <= f_scale(r_mem_i[w_rd_bank_nx][w_idx_nx]);
            bus.index_o       <= w_idx_nx;
        end else begin
            bus.valid_o       <= 1'b0;
            bus.frame_start_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fft_reorder.sv
// tb_fft_reorder: directed stimulus with a scoreboard of expected bins.
module tb_fft_reorder;
    localparam int DW = 17;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_reorder_if #(.DW(DW)) bus ();
    fft_reorder #(.DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int idx;
        int re;
        int im;
        int fs;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int mcnt = 0;
    int fr_re[32];
    int fr_im[32];
    int vcnt = 0;
    int run = 0;
    int maxrun = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int bitrev(input int a);
        int r;
        r = 0;
        for (int b = 0; b < 5; b++) if (a[b]) r = r | (1 << (4 - b));
        return r;
    endfunction

    function automatic int scl(input int x);
`ifdef FFT_REORDER_SCALE_EN
        int t;
        logic signed [DW-1:0] s;
        t = (x + 16) >>> 5;
        s = t[DW-1:0];
        return int'(s);
`else
        return x;
`endif
    endfunction

    // Drive one cycle of input; the model records accepted samples and
    // queues the natural-order frame once the 32nd sample is taken.
    task automatic drive(input bit v, input int re, input int im);
        exp_t e;
        bus.valid_i   = v;
        bus.data_in_r = re[DW-1:0];
        bus.data_in_i = im[DW-1:0];
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        if (v) begin
            fr_re[mcnt] = re;
            fr_im[mcnt] = im;
            mcnt++;
            if (mcnt == 32) begin
                mcnt = 0;
                for (int i = 0; i < 32; i++) begin
                    e.idx = i;
                    e.re  = scl(fr_re[bitrev(i)]);
                    e.im  = scl(fr_im[bitrev(i)]);
                    e.fs  = (i == 0) ? 1 : 0;
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_valid", bus.valid_o, 0);
        chk("rst_fs", bus.frame_start_o, 0);
        chk("rst_re", bus.data_out_r, 0);
        chk("rst_im", bus.data_out_i, 0);
        chk("rst_idx", bus.index_o, 0);
        q.delete();
        mcnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: every valid output must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.valid_o === 1'b1) begin
            vcnt++;
            run++;
            if (run > maxrun) maxrun = run;
            if (q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("idx", bus.index_o, e.idx);
                chk("re", bus.data_out_r, e.re);
                chk("im", bus.data_out_i, e.im);
                chk("fs", bus.frame_start_o, e.fs);
            end
        end else begin
            run = 0;
        end
    end

    initial begin
        int vsave;
        bus.valid_i   = 1'b0;
        bus.data_in_r = '0;
        bus.data_in_i = '0;
        #1;
        do_reset();
        idle(3);
        chk("idle_valid", bus.valid_o, 0);

        // Consecutive frame, re=wr_cnt, im=-wr_cnt
        for (int k = 0; k < 32; k++) drive(1'b1, k, -k);
        @(negedge clk);
        chk("lat_a_valid", bus.valid_o, 1);
        chk("lat_a_idx", bus.index_o, 0);
        chk("lat_a_re", bus.data_out_r, scl(0));
        #1;
        idle(40);
        chk("after_a_valid", bus.valid_o, 0);
        chk("after_a_fs", bus.frame_start_o, 0);

        // Same frame with a gap after every sample
        for (int k = 0; k < 32; k++) begin
            if (k > 0) drive(1'b0, 0, 0);
            drive(1'b1, k, -k);
        end
        @(negedge clk);
        chk("lat_b_valid", bus.valid_o, 1);
        chk("lat_b_fs", bus.frame_start_o, 1);
        #1;
        idle(40);

        // Two frames back to back
        maxrun = 0;
        for (int k = 0; k < 64; k++) drive(1'b1, k * 3 - 50, 40 - k);
        idle(40);
        chk("b2b_run", maxrun, 64);

        // Scaling corner values at the start of a frame
        for (int k = 0; k < 32; k++) begin
            case (k)
                0: drive(1'b1, 65535, -k);
                1: drive(1'b1, -65536, -k);
                2: drive(1'b1, 15, -k);
                3: drive(1'b1, 16, -k);
                default: drive(1'b1, k * 1000 - 9000, -k);
            endcase
        end
        idle(40);

        // Reset after 20 samples discards the partial frame
        for (int k = 0; k < 20; k++) drive(1'b1, k + 5, k - 5);
        do_reset();
        vsave = vcnt;
        for (int k = 0; k < 31; k++) drive(1'b1, 100 + k, -100 - k);
        idle(10);
        chk("post_rst_quiet", vcnt, vsave);
        drive(1'b1, 131, -131);
        @(negedge clk);
        chk("post_rst_valid", bus.valid_o, 1);
        chk("post_rst_idx", bus.index_o, 0);
        #1;
        idle(40);

        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
